// File: rtl/size_store_rmw_if.sv
// Store request / memory bus bundle for size_store_rmw.
// slave: the store engine; master: the requester plus memory side.
interface size_store_rmw_if;
  logic        start;
  logic [1:0]  SSizeCtrl;
  logic [31:0] addr;
  logic [31:0] data_in_B;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;

  modport slave (
    input  start,
    input  SSizeCtrl,
    input  addr,
    input  data_in_B,
    input  mem_rdata,
    output mem_addr,
    output mem_wdata,
    output mem_wr,
    output busy,
    output done
  );

  modport master (
    output start,
    output SSizeCtrl,
    output addr,
    output data_in_B,
    output mem_rdata,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wr,
    input  busy,
    input  done
  );
endinterface

// File: rtl/size_store_rmw.sv
// Sized store engine: byte and halfword stores do a read-modify-write of
// the addressed memory word, word stores write straight through.
module size_store_rmw (
  input  logic             clk,
  input  logic             reset,
  size_store_rmw_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  state_t      state;
  state_t      state_next;

  // Request captured at acceptance; later input changes are invisible.
  logic [31:0] addr_reg;
  logic [15:0] b_low_reg;
  logic [1:0]  size_reg;
  logic [31:0] merge_reg;
  logic [31:0] merged;

  logic        accept;
  logic        req_is_word;

  logic        mem_wr_int;
  logic        busy_int;
  logic        done_int;

  // Only the two sub-word codes need a read; every other code is a word.
  assign req_is_word = (bus.SSizeCtrl != SIZE_HALF) && (bus.SSizeCtrl != SIZE_BYTE);
  assign accept      = (state == IDLE) && bus.start;

  // State register; reset drops straight to IDLE, which also kills mem_wr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: fixed walk through the sequence, no queuing of starts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = req_is_word ? WRITE : READ;
        end
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state alone.
  always_comb begin
    mem_wr_int = 1'b0;
    busy_int   = 1'b1;
    done_int   = 1'b0;
    case (state)
      IDLE:    busy_int   = 1'b0;
      WRITE:   mem_wr_int = 1'b1;
      DONE:    done_int   = 1'b1;
      default: ;
    endcase
  end

  // Merge combines the fresh read word with the low bits of the register value.
  always_comb begin
    merged = merge_reg;
    case (size_reg)
      SIZE_HALF: merged = {bus.mem_rdata[31:16], b_low_reg[15:0]};
      SIZE_BYTE: merged = {bus.mem_rdata[31:8],  b_low_reg[7:0]};
      default:   merged = merge_reg;
    endcase
  end

  // Latch the request on acceptance and capture the merged word in MERGE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= 32'd0;
      b_low_reg <= 16'd0;
      size_reg  <= 2'b00;
      merge_reg <= 32'd0;
    end else if (accept) begin
      addr_reg  <= bus.addr;
      b_low_reg <= bus.data_in_B[15:0];
      size_reg  <= bus.SSizeCtrl;
      // A word store needs no read, so its write data is known right away.
      if (req_is_word) begin
        merge_reg <= bus.data_in_B;
      end
    end else if (state == MERGE) begin
      merge_reg <= merged;
    end
  end

  // Address and write data come straight from registers; they hold in IDLE.
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = merge_reg;
  assign bus.mem_wr    = mem_wr_int;
  assign bus.busy      = busy_int;
  assign bus.done      = done_int;

endmodule

// File: tb/tb_size_store_rmw.sv
// Bench for size_store_rmw: a word memory model answers reads one cycle
// late, a queue of expected writes and done pulses is checked as they occur.
module tb_size_store_rmw;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  size_store_rmw_if bus ();

  size_store_rmw dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } wr_exp_t;

  wr_exp_t     wq[$];
  int          dq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  // Cycle n is the cycle that follows the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read data, write on the strobe, bench preload.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end

  function automatic logic [31:0] merge_exp(logic [1:0] sz, logic [31:0] old, logic [31:0] b);
    case (sz)
      2'b01:   return {old[31:16], b[15:0]};
      2'b10:   return {old[31:8], b[7:0]};
      default: return b;
    endcase
  endfunction

  task automatic monitor();
    wr_exp_t e;
    int      dc;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_wr === 1'b1) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
          end else begin
            e = wq.pop_front();
            if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d || cyc !== e.cyc) begin
              errors++;
              $display("FAIL write got addr=%h data=%h cycle=%0d want addr=%h data=%h cycle=%0d",
                       bus.mem_addr, bus.mem_wdata, cyc, e.a, e.d, e.cyc);
            end
          end
        end
        if (bus.done === 1'b1) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cycle=%0d", cyc);
          end else begin
            dc = dq.pop_front();
            if (cyc !== dc) begin
              errors++;
              $display("FAIL done_cycle got %0d want %0d", cyc, dc);
            end
          end
        end
      end
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = a[7:2];
    poke_val = v;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_wr !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s got addr=%h wdata=%h wr=%b busy=%b done=%b want all 0",
               name, bus.mem_addr, bus.mem_wdata, bus.mem_wr, bus.busy, bus.done);
    end
  endtask

  // One complete store from IDLE, with inputs scrambled while busy.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] exp);
    int c;
    int n;
    @(negedge clk);
    c   = cyc;
    n   = (sz == 2'b01 || sz == 2'b10) ? 4 : 2;
    exp = merge_exp(sz, mem[a[7:2]], b);
    wq.push_back('{a: a, d: exp, cyc: c + n - 1});
    dq.push_back(c + n);
    bus.start     = 1'b1;
    bus.SSizeCtrl = sz;
    bus.addr      = a;
    bus.data_in_B = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy cycle+%0d got %b want 1", i, bus.busy);
      end
      bus.addr      = $urandom;
      bus.data_in_B = $urandom;
      bus.SSizeCtrl = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_addr !== a || bus.mem_wdata !== exp ||
        wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL idle_after_store busy=%b addr=%h wdata=%h pending=%0d/%0d want busy=0 addr=%h wdata=%h none",
               bus.busy, bus.mem_addr, bus.mem_wdata, wq.size(), dq.size(), a, exp);
    end
    checks++;
    if (mem[a[7:2]] !== exp) begin
      errors++;
      $display("FAIL mem_after_store got %h want %h", mem[a[7:2]], exp);
    end
    $display("store size=%b addr=%h b=%h -> %h", sz, a, b, exp);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
    reset = 1'b0;
  endtask

  task automatic test_byte();
    logic [31:0] e;
    poke(32'h40, 32'hAABBCCDD);
    do_store(2'b10, 32'h40, 32'h12345678, e);
    checks++;
    if (mem[16] !== 32'hAABBCC78) begin
      errors++;
      $display("FAIL byte_result got %h want aabbcc78", mem[16]);
    end
  endtask

  task automatic test_half();
    logic [31:0] e;
    poke(32'h40, 32'hAABBCCDD);
    do_store(2'b01, 32'h40, 32'h12345678, e);
    checks++;
    if (mem[16] !== 32'hAABB5678) begin
      errors++;
      $display("FAIL half_result got %h want aabb5678", mem[16]);
    end
  endtask

  task automatic test_word();
    logic [31:0] e;
    poke(32'h40, 32'h11111111);
    poke(32'h50, 32'h22222222);
    do_store(2'b11, 32'h40, 32'hDEADBEEF, e);
    do_store(2'b00, 32'h50, 32'hDEADBEEF, e);
    checks++;
    if (mem[16] !== 32'hDEADBEEF || mem[20] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_result got %h %h want deadbeef", mem[16], mem[20]);
    end
  endtask

  // start held high throughout a byte store: one write, next accept after done.
  task automatic test_back_to_back();
    int          c;
    logic [31:0] exp1;
    poke(32'h60, 32'hA5A5A5A5);
    poke(32'h64, 32'h0F0F0F0F);
    @(negedge clk);
    c    = cyc;
    exp1 = 32'hA5A5A534;
    wq.push_back('{a: 32'h60, d: exp1, cyc: c + 3});
    dq.push_back(c + 4);
    bus.start     = 1'b1;
    bus.SSizeCtrl = 2'b10;
    bus.addr      = 32'h60;
    bus.data_in_B = 32'h00000034;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.addr      = $urandom;
      bus.data_in_B = $urandom;
      bus.SSizeCtrl = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    // Cycle c+4 is DONE: start here must be ignored; accepted at the end of c+5.
    bus.addr      = 32'h64;
    bus.data_in_B = 32'h13572468;
    bus.SSizeCtrl = 2'b11;
    wq.push_back('{a: 32'h64, d: 32'h13572468, cyc: c + 6});
    dq.push_back(c + 7);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap busy got %b want 0", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem[24] !== exp1 || mem[25] !== 32'h13572468 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL b2b_result got %h %h pending=%0d want %h 13572468 none",
               mem[24], mem[25], wq.size(), exp1);
    end
    $display("back_to_back byte then word done");
  endtask

  task automatic test_reset_merge();
    logic [31:0] e;
    poke(32'h40, 32'hAABBCCDD);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.SSizeCtrl = 2'b01;
    bus.addr      = 32'h40;
    bus.data_in_B = 32'h12345678;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_in_merge");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (mem[16] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL mem_after_abort got %h want aabbccdd", mem[16]);
    end
    $display("reset during merge abandoned store");
    do_store(2'b00, 32'h44, 32'hCAFEF00D, e);
  endtask

  task automatic test_reset_write();
    poke(32'h48, 32'h5A5A5A5A);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.SSizeCtrl = 2'b11;
    bus.addr      = 32'h48;
    bus.data_in_B = 32'h01020304;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write wr=%b busy=%b want 0 0", bus.mem_wr, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (mem[18] !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL mem_after_write_abort got %h want 5a5a5a5a", mem[18]);
    end
    $display("reset during write abandoned store");
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.SSizeCtrl = 2'b00;
    bus.addr      = 32'd0;
    bus.data_in_B = 32'd0;
    poke_en       = 1'b0;
    poke_idx      = 6'd0;
    poke_val      = 32'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_byte();
    test_half();
    test_word();
    test_back_to_back();
    test_reset_merge();
    test_reset_write();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
